uncached_data_port: RTL and testbench
=====================================

# uncached_data_port

Responder for the MEM-stage pipeline control: it services one uncached load or store at a time on a simple request/address-ok/data-ok bus. It drives the `busy` and `data_ok` pair that the write/flush control consumes to stall the pipeline. It sits between the MEM stage and the bus arbiter, in parallel with the data cache, and obeys the exception flush that the control unit issues.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.

Ports (reset is asynchronous and active-low, one clock):
- `clk` in 1: clock.
- `resetn` in 1: asynchronous active-low reset.
- `cpu_req` in 1: MEM stage holds an uncached access; held stable by the pipeline while `busy`=1.
- `cpu_wr` in 1: 1 = store, 0 = load.
- `cpu_size` in 2: 0 byte, 1 half, 2 word.
- `cpu_addr` in ADDR_W: access address.
- `cpu_wdata` in DATA_W: store data.
- `cpu_wstrb` in DATA_W/8: byte strobes.
- `flush` in 1: exception flush, same cycle as the control unit's cache flush.
- `busy` out 1: 1 = stall the pipeline.
- `data_ok` out 1: one-cycle completion pulse for the current access.
- `rdata` out DATA_W: load data, valid while `data_ok`=1.
- `bus_req` out 1, `bus_wr` out 1, `bus_size` out 2, `bus_addr` out ADDR_W, `bus_wdata` out DATA_W, `bus_wstrb` out DATA_W/8: bus request. These fields stay stable from `bus_req` rise to `bus_addr_ok`.
- `bus_addr_ok` in 1: request accepted.
- `bus_data_ok` in 1: read data returned or write acknowledged.
- `bus_rdata` in DATA_W: bus read data.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP. A `cancel` flag is kept alongside it.
- **IDLE**
  - `cpu_req`=1 and `flush`=0: latch addr/size/wr/wdata/wstrb and go to REQ.
  - `flush`=1: nothing is latched.
- **REQ**
  - `bus_req`=1 with the latched fields.
  - `bus_addr_ok`=1: go to WAIT.
- **WAIT**
  - `bus_data_ok`=1 with `cancel`=0: register `bus_rdata`, go to RESP.
  - `bus_data_ok`=1 with `cancel`=1: go to IDLE and clear `cancel`.
- **RESP**
  - `data_ok`=1, `busy`=0, `rdata` driven.
  - Go to IDLE unconditionally.
- **busy**
  - In IDLE: `busy` = `cpu_req` & ~`flush`.
  - In REQ and WAIT: `busy`=1 if `cancel`=0; if `cancel`=1, `busy` = `cpu_req`.
  - In RESP: `busy`=0.
- **Flush in REQ or WAIT**
  - Set `cancel`. The bus transaction is never withdrawn after `bus_req` rises.
  - It drains without `data_ok`.
  - A new `cpu_req` during the drain waits until IDLE.
- `rdata` is the raw aligned word. Byte and halfword extraction is done in the WB stage.

## Timing
- Reset values: state IDLE, `cancel`=0, `bus_req`=0, `data_ok`=0, `rdata`=0, all bus fields 0.
- `busy` is combinational from `cpu_req`/`flush` only in IDLE; everything else is registered.
- Minimum load latency is 4 cycles: IDLE, REQ (with `addr_ok` in the same cycle), WAIT (with `data_ok` in the same cycle), RESP.
- `flush` and `bus_data_ok` in the same WAIT cycle: the flush wins, so there is no RESP and the FSM returns to IDLE.
- `flush` in RESP: ignored; `data_ok` still pulses and the control unit discards it.
- `resetn` low mid-transaction: immediate return to IDLE and `bus_req` drops.
  - This is legal only because the bus is reset together with the core.

## Configuration
- The macro is `UNCACHED_WBUF_EN`. Without it, stores follow the load path exactly.
- With it, a one-entry store buffer is added:
  - A store in IDLE with the buffer empty and `flush`=0 is captured. `busy`=0 and `data_ok`=1 occur combinationally in that cycle.
  - The buffer drains through REQ and WAIT with `cancel` forced 0; `flush` never cancels a buffered store.
  - While the buffer is occupied, any `cpu_req` sees `busy`=1 until the drain completes. The request then starts in IDLE on the following cycle.

## Test plan
- Load to 0x1FAF_F000; `bus_addr_ok` 1 cycle after REQ; `bus_data_ok` with 0xDEAD_BEEF 2 cycles later -> `busy`=1 for 5 cycles, one `data_ok` with `rdata`=0xDEAD_BEEF, then `busy`=0.
- Store 0x0000_00AA with size 0, wstrb 4'b0001, addr 0x1FD0_0003 (macro off) -> `bus_wr`=1, same fields on the bus, `data_ok` one cycle after `bus_data_ok`.
- `flush`=1 in the IDLE cycle of a load -> `bus_req` never rises, `busy`=0, no `data_ok`.
- `flush` in WAIT, then a new load presented -> `busy`=1 until the old `bus_data_ok`. No `data_ok` for the old load; the new load's REQ starts 1 cycle after the drain.
- Macro on: two back-to-back stores with `bus_addr_ok` delayed 3 cycles -> first store `data_ok` immediately; second `busy`=1 until the first drains, then accepted.
- `resetn` asserted in WAIT -> next cycle state IDLE, all outputs at their reset values.

Source files
------------

// File: rtl/uncached_data_port.sv
// ---------------------------------------------------------------------------
// uncached_data_port
//   Services one uncached load or store at a time for the MEM stage on a
//   request / addr_ok / data_ok bus. Drives busy/data_ok to the pipeline
//   control and honours the exception flush by cancelling (draining) an
//   in-flight bus transaction without reporting completion.
//
// Optional feature (macro UNCACHED_WBUF_EN):
//   One-entry store buffer. A store accepted in IDLE completes to the CPU
//   immediately (combinational data_ok, busy=0) and drains on the bus
//   afterwards. Without the macro, stores follow the load path.
//
// Ports
//   clk, resetn                    clock, async active-low reset
//   cpu_req/wr/size/addr/wdata/wstrb  MEM-stage access request
//   flush                          exception flush
//   busy, data_ok, rdata           pipeline stall / completion / load data
//   bus_req/wr/size/addr/wdata/wstrb  bus request (registered, stable)
//   bus_addr_ok, bus_data_ok, bus_rdata  bus handshake and read data
// ---------------------------------------------------------------------------
module uncached_data_port #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_wstrb,
  input  logic                  flush,
  output logic                  busy,
  output logic                  data_ok,
  output logic [DATA_W-1:0]     rdata,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_cancel;
  logic                w_cancel_nxt;
  logic                r_wbuf_vld;
  logic                w_wbuf_nxt;
  logic                w_latch;
  logic                w_rdata_ld;
  logic                w_wbuf_take;
  logic                w_busy;
  logic                w_quiet;

  logic                r_bus_req;
  logic                r_data_ok;
  logic                r_bus_wr;
  logic [1:0]          r_bus_size;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [STRB_W-1:0]   r_bus_wstrb;
  logic [DATA_W-1:0]   r_rdata;

  // A cancelled access or a buffered store drains silently: no data_ok,
  // and the stall only reflects whether a new request is waiting.
  assign w_quiet = r_cancel | r_wbuf_vld;

  // Next-state, stall and load-enable decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    w_wbuf_nxt   = r_wbuf_vld;
    w_latch      = 1'b0;
    w_rdata_ld   = 1'b0;
    w_wbuf_take  = 1'b0;
    w_busy       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_busy = cpu_req & ~flush;
        if (cpu_req && !flush) begin
          w_latch     = 1'b1;
          w_state_nxt = S_REQ;
`ifdef UNCACHED_WBUF_EN
          // Store is retired to the CPU now and drained from the bus fields.
          if (cpu_wr) begin
            w_wbuf_take = 1'b1;
            w_wbuf_nxt  = 1'b1;
            w_busy      = 1'b0;
          end
`endif
        end
      end
      S_REQ: begin
        w_busy = w_quiet ? cpu_req : 1'b1;
        if (flush && !r_wbuf_vld) w_cancel_nxt = 1'b1;
        if (bus_addr_ok) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_busy = w_quiet ? cpu_req : 1'b1;
        if (bus_data_ok) begin
          // Flush in the same cycle as data return wins over the response.
          if (w_quiet || flush) begin
            w_state_nxt  = S_IDLE;
            w_cancel_nxt = 1'b0;
            w_wbuf_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_RESP;
            w_rdata_ld  = 1'b1;
          end
        end else if (flush && !r_wbuf_vld) begin
          w_cancel_nxt = 1'b1;
        end
      end
      S_RESP: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state and registered handshake outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cancel   <= 1'b0;
      r_wbuf_vld <= 1'b0;
      r_bus_req  <= 1'b0;
      r_data_ok  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cancel   <= w_cancel_nxt;
      r_wbuf_vld <= w_wbuf_nxt;
      r_bus_req  <= (w_state_nxt == S_REQ);
      r_data_ok  <= (w_state_nxt == S_RESP);
    end
  end

  // Request fields (held until the next accepted access) and load data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bus_wr    <= 1'b0;
      r_bus_size  <= 2'd0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_latch) begin
        r_bus_wr    <= cpu_wr;
        r_bus_size  <= cpu_size;
        r_bus_addr  <= cpu_addr;
        r_bus_wdata <= cpu_wdata;
        r_bus_wstrb <= cpu_wstrb;
      end
      if (w_rdata_ld) r_rdata <= bus_rdata;
    end
  end

  assign busy      = w_busy;
  assign data_ok   = r_data_ok | w_wbuf_take;
  assign rdata     = r_rdata;
  assign bus_req   = r_bus_req;
  assign bus_wr    = r_bus_wr;
  assign bus_size  = r_bus_size;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_uncached_data_port.sv
// ---------------------------------------------------------------------------
// tb_uncached_data_port
//   Directed self-checking bench for uncached_data_port. Inputs are driven
//   1ns after the rising edge, outputs sampled on the falling edge.
//   Set UNCACHED_WBUF_EN to exercise the store-buffer build.
// ---------------------------------------------------------------------------
module tb_uncached_data_port;

  logic        clk;
  logic        resetn;
  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        flush;
  logic        busy;
  logic        data_ok;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_checks;
  int n_errors;

  uncached_data_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_size   (cpu_size),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wstrb  (cpu_wstrb),
    .flush      (flush),
    .busy       (busy),
    .data_ok    (data_ok),
    .rdata      (rdata),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_size   (bus_size),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, data_ok, bus_req, bus_wr} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl got busy/dok/req/wr=%b want 0000", {busy, data_ok, bus_req, bus_wr});
    end
    n_checks++;
    if ({rdata, bus_addr, bus_wdata, bus_wstrb, bus_size} !== 102'd0) begin
      n_errors++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rdata, bus_addr, bus_wdata);
    end
    resetn = 1'b1;
    nc();
  endtask

  // Load with addr_ok one cycle late and data_ok two cycles after addr_ok.
  task automatic test_load();
    int busy_cnt;
    int dok_cnt;
    busy_cnt = 0;
    dok_cnt  = 0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h1FAF_F000;
    cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
    @(negedge clk);                                   // IDLE
    if (busy) busy_cnt++;
    if (data_ok) dok_cnt++;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_errors++;
      $display("FAIL load_idle_req got %b want 0", bus_req);
    end
    nc();
    @(negedge clk);                                   // REQ
    if (busy) busy_cnt++;
    if (data_ok) dok_cnt++;
    n_checks++;
    if ({bus_req, bus_wr, bus_size, bus_addr} !== {1'b1, 1'b0, 2'd2, 32'h1FAF_F000}) begin
      n_errors++;
      $display("FAIL load_req_fields got req=%b wr=%b size=%0d addr=%h", bus_req, bus_wr, bus_size, bus_addr);
    end
    nc(); bus_addr_ok = 1'b1;
    @(negedge clk);                                   // REQ, accepted
    if (busy) busy_cnt++;
    if (data_ok) dok_cnt++;
    nc(); bus_addr_ok = 1'b0;
    @(negedge clk);                                   // WAIT
    if (busy) busy_cnt++;
    if (data_ok) dok_cnt++;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_errors++;
      $display("FAIL load_wait_req got %b want 0", bus_req);
    end
    nc(); bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);                                   // WAIT, data back
    if (busy) busy_cnt++;
    if (data_ok) dok_cnt++;
    nc(); bus_data_ok = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);                                   // RESP
    if (busy) busy_cnt++;
    if (data_ok) dok_cnt++;
    n_checks++;
    if ({data_ok, busy, rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_errors++;
      $display("FAIL load_resp got dok=%b busy=%b rdata=%h want 1 0 deadbeef", data_ok, busy, rdata);
    end
    nc(); cpu_req = 1'b0;
    @(negedge clk);                                   // IDLE
    if (busy) busy_cnt++;
    if (data_ok) dok_cnt++;
    n_checks++;
    if (busy_cnt != 5 || dok_cnt != 1) begin
      n_errors++;
      $display("FAIL load_counts got busy=%0d dok=%0d want 5 1", busy_cnt, dok_cnt);
    end
    nc();
  endtask

`ifndef UNCACHED_WBUF_EN
  // Byte store follows the load path.
  task automatic test_store();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd0; cpu_addr = 32'h1FD0_0003;
    cpu_wdata = 32'h0000_00AA; cpu_wstrb = 4'b0001;
    @(negedge clk);                                   // IDLE
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL store_idle_busy got %b want 1", busy);
    end
    nc(); bus_addr_ok = 1'b1;
    @(negedge clk);                                   // REQ
    n_checks++;
    if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb} !==
        {1'b1, 1'b1, 2'd0, 32'h1FD0_0003, 32'h0000_00AA, 4'b0001}) begin
      n_errors++;
      $display("FAIL store_req_fields got wr=%b size=%0d addr=%h wdata=%h wstrb=%b",
               bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb);
    end
    nc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    @(negedge clk);                                   // WAIT, acked
    n_checks++;
    if ({data_ok, busy} !== 2'b01) begin
      n_errors++;
      $display("FAIL store_wait got dok/busy=%b want 01", {data_ok, busy});
    end
    nc(); bus_data_ok = 1'b0;
    @(negedge clk);                                   // RESP
    n_checks++;
    if ({data_ok, busy} !== 2'b10) begin
      n_errors++;
      $display("FAIL store_resp got dok/busy=%b want 10", {data_ok, busy});
    end
    nc(); cpu_req = 1'b0;
  endtask
`endif

  // Flush in the IDLE cycle: nothing starts.
  task automatic test_flush_idle();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h1FAF_0010; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_idle_busy got %b want 0", busy);
    end
    nc(); cpu_req = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus_req, data_ok} !== 2'b00) begin
        n_errors++;
        $display("FAIL flush_idle_quiet got req/dok=%b want 00 (cycle %0d)", {bus_req, data_ok}, i);
      end
      nc();
    end
  endtask

  // Flush in WAIT, then a new load waits for the old drain.
  task automatic test_flush_wait();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h1FAF_0100;
    nc(); bus_addr_ok = 1'b1;                         // REQ
    nc(); bus_addr_ok = 1'b0; flush = 1'b1;           // WAIT, flush
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL fw_flush_busy got %b want 1", busy);
    end
    nc(); flush = 1'b0; cpu_addr = 32'h1FAF_0200;     // WAIT cancelled, new load
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL fw_newreq_busy got %b want 1", busy);
    end
    nc(); bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678; // old drains
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL fw_drain_busy got %b want 1", busy);
    end
    nc(); bus_data_ok = 1'b0;                         // IDLE
    @(negedge clk);
    n_checks++;
    if ({data_ok, bus_req, busy} !== 3'b001) begin
      n_errors++;
      $display("FAIL fw_idle got dok/req/busy=%b want 001", {data_ok, bus_req, busy});
    end
    nc(); bus_addr_ok = 1'b1;                         // new REQ
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_addr, data_ok} !== {1'b1, 32'h1FAF_0200, 1'b0}) begin
      n_errors++;
      $display("FAIL fw_new_req got req=%b addr=%h dok=%b", bus_req, bus_addr, data_ok);
    end
    nc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    nc(); bus_data_ok = 1'b0; flush = 1'b1;           // RESP with flush
    @(negedge clk);
    n_checks++;
    if ({data_ok, rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      n_errors++;
      $display("FAIL fw_new_resp got dok=%b rdata=%h want 1 cafef00d", data_ok, rdata);
    end
    nc(); flush = 1'b0; cpu_req = 1'b0;
  endtask

  // Flush and bus_data_ok in the same WAIT cycle: flush wins.
  task automatic test_flush_race();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h1FAF_0300;
    nc(); bus_addr_ok = 1'b1;
    nc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA; flush = 1'b1;
    nc(); bus_data_ok = 1'b0; flush = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({data_ok, busy, bus_req} !== 3'b000 || rdata !== 32'hCAFE_F00D) begin
        n_errors++;
        $display("FAIL race_no_resp got dok/busy/req=%b rdata=%h (cycle %0d)",
                 {data_ok, busy, bus_req}, rdata, i);
      end
      nc();
    end
  endtask

  // Asynchronous reset while in WAIT.
  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd2; cpu_addr = 32'h1FAF_0400;
    cpu_wdata = 32'h7777_8888; cpu_wstrb = 4'hF;
    nc(); bus_addr_ok = 1'b1;
    nc(); bus_addr_ok = 1'b0;
    @(negedge clk);                                   // WAIT
    resetn = 1'b0; cpu_req = 1'b0;
    #1;
    n_checks++;
    if ({busy, data_ok, bus_req, bus_wr, rdata, bus_addr, bus_wdata, bus_wstrb, bus_size} !== 106'd0) begin
      n_errors++;
      $display("FAIL rstmid_outputs got busy=%b dok=%b req=%b rdata=%h addr=%h wdata=%h",
               busy, data_ok, bus_req, rdata, bus_addr, bus_wdata);
    end
    @(negedge clk);
    resetn = 1'b1;
    nc(); bus_data_ok = 1'b1;                         // stray ack must be ignored
    nc(); bus_data_ok = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_ok, busy, bus_req} !== 3'b000) begin
      n_errors++;
      $display("FAIL rstmid_idle got dok/busy/req=%b want 000", {data_ok, busy, bus_req});
    end
    nc();
  endtask

`ifdef UNCACHED_WBUF_EN
  // Two back-to-back stores through the store buffer, addr_ok late.
  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd2; cpu_addr = 32'h1FD0_0010;
    cpu_wdata = 32'h1111_1111; cpu_wstrb = 4'hF;
    @(negedge clk);                                   // IDLE, captured
    n_checks++;
    if ({busy, data_ok} !== 2'b01) begin
      n_errors++;
      $display("FAIL wb_first_take got busy/dok=%b want 01", {busy, data_ok});
    end
    nc(); cpu_addr = 32'h1FD0_0020; cpu_wdata = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin                 // REQ, addr_ok withheld
      @(negedge clk);
      n_checks++;
      if ({busy, data_ok, bus_req, bus_addr} !== {3'b101, 32'h1FD0_0010}) begin
        n_errors++;
        $display("FAIL wb_drain_hold got busy=%b dok=%b req=%b addr=%h (cycle %0d)",
                 busy, data_ok, bus_req, bus_addr, i);
      end
      nc();
    end
    bus_addr_ok = 1'b1;
    nc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1;     // WAIT, acked
    @(negedge clk);
    n_checks++;
    if ({busy, data_ok} !== 2'b10) begin
      n_errors++;
      $display("FAIL wb_drain_ack got busy/dok=%b want 10", {busy, data_ok});
    end
    nc(); bus_data_ok = 1'b0;                         // IDLE, second captured
    @(negedge clk);
    n_checks++;
    if ({busy, data_ok} !== 2'b01) begin
      n_errors++;
      $display("FAIL wb_second_take got busy/dok=%b want 01", {busy, data_ok});
    end
    nc(); cpu_req = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_addr, bus_wdata, data_ok} !== {1'b1, 32'h1FD0_0020, 32'h2222_2222, 1'b0}) begin
      n_errors++;
      $display("FAIL wb_second_req got req=%b addr=%h wdata=%h dok=%b", bus_req, bus_addr, bus_wdata, data_ok);
    end
    nc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    nc(); bus_data_ok = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_ok, busy, bus_req} !== 3'b000) begin
      n_errors++;
      $display("FAIL wb_second_done got dok/busy/req=%b want 000", {data_ok, busy, bus_req});
    end
    nc();
  endtask
`endif

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    resetn      = 1'b0;
    cpu_req     = 1'b0;
    cpu_wr      = 1'b0;
    cpu_size    = 2'd0;
    cpu_addr    = 32'h0;
    cpu_wdata   = 32'h0;
    cpu_wstrb   = 4'h0;
    flush       = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;

    test_reset();
    test_load();
`ifndef UNCACHED_WBUF_EN
    test_store();
`endif
    test_flush_idle();
    test_flush_wait();
    test_flush_race();
`ifdef UNCACHED_WBUF_EN
    test_back_to_back();
`endif
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
